// File: rtl/sdram_frame_sched.sv
// Triple-buffer frame scheduler: rotates three SDRAM frame buffers between the camera
// writer and the display reader, and drives the address windows and FIFO clear pulses.
module sdram_frame_sched #(
  parameter logic [23:0] BASE_ADDR  = 24'h000000,
  parameter logic [23:0] BUF_STRIDE = 24'h080000,
  parameter logic [23:0] FRAME_SIZE = 24'd307200,
  parameter logic [9:0]  BURST_LEN  = 10'd512,
  parameter int          RST_CYCLES = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic        wr_frame_start,
  input  logic        rd_frame_start,
  output logic [23:0] sdram_wr_b_addr,
  output logic [23:0] sdram_wr_e_addr,
  output logic [23:0] sdram_rd_b_addr,
  output logic [23:0] sdram_rd_e_addr,
  output logic [9:0]  wr_burst_len,
  output logic [9:0]  rd_burst_len,
  output logic        wr_rst,
  output logic        rd_rst,
  output logic        read_valid,
  output logic [1:0]  wr_buf_idx,
  output logic [1:0]  rd_buf_idx,
  output logic        frame_drop,
  output logic        frame_repeat
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_RST = 2'd1, W_RUN = 2'd2} wr_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_RST = 2'd1, R_RUN = 2'd2} rd_state_t;

  localparam logic [3:0] RST_LOAD = 4'(RST_CYCLES - 1);

  function automatic logic [23:0] buf_base(input logic [1:0] idx);
    case (idx)
      2'd0:    buf_base = BASE_ADDR;
      2'd1:    buf_base = BASE_ADDR + BUF_STRIDE;
      2'd2:    buf_base = BASE_ADDR + BUF_STRIDE + BUF_STRIDE;
      default: buf_base = BASE_ADDR;
    endcase
  endfunction

  function automatic logic [1:0] free_idx(input logic [1:0] a, input logic [1:0] b);
    if (a != 2'd0 && b != 2'd0) begin
      free_idx = 2'd0;
    end else if (a != 2'd1 && b != 2'd1) begin
      free_idx = 2'd1;
    end else begin
      free_idx = 2'd2;
    end
  endfunction

  wr_state_t  wr_state_r, wr_state_nxt;
  rd_state_t  rd_state_r, rd_state_nxt;
  logic [3:0] wr_cnt_r, wr_cnt_nxt, rd_cnt_r, rd_cnt_nxt;
  logic [1:0] wr_idx_r, wr_idx_nxt, rd_idx_r, rd_idx_nxt, lat_idx_r, lat_idx_nxt;
  logic       lat_vld_r, lat_vld_nxt, fresh_r, fresh_nxt;
  logic       wr_rst_nxt, rd_rst_nxt, read_valid_nxt, drop_nxt, repeat_nxt;
  logic       wr_pick_s, rd_take_s;

  assign wr_burst_len = BURST_LEN;
  assign rd_burst_len = BURST_LEN;
  assign wr_buf_idx   = wr_idx_r;
  assign rd_buf_idx   = rd_idx_r;

  // Next-state for both FSMs; the writer commit is resolved first so a simultaneous read sees it.
  always_comb begin
    wr_state_nxt   = wr_state_r;
    rd_state_nxt   = rd_state_r;
    wr_cnt_nxt     = wr_cnt_r;
    rd_cnt_nxt     = rd_cnt_r;
    wr_idx_nxt     = wr_idx_r;
    rd_idx_nxt     = rd_idx_r;
    lat_idx_nxt    = lat_idx_r;
    lat_vld_nxt    = lat_vld_r;
    fresh_nxt      = fresh_r;
    wr_rst_nxt     = wr_rst;
    rd_rst_nxt     = rd_rst;
    read_valid_nxt = read_valid;
    drop_nxt       = 1'b0;
    repeat_nxt     = 1'b0;
    wr_pick_s      = 1'b0;
    rd_take_s      = 1'b0;

    case (wr_state_r)
      W_IDLE: begin
        if (init_end && wr_frame_start) begin
          wr_pick_s    = 1'b1;
          wr_state_nxt = W_RST;
          wr_cnt_nxt   = RST_LOAD;
          wr_rst_nxt   = 1'b1;
        end else begin
          wr_rst_nxt   = 1'b0;
        end
      end
      W_RST: begin
        if (wr_cnt_r == 4'd0) begin
          wr_state_nxt = W_RUN;
          wr_rst_nxt   = 1'b0;
        end else begin
          wr_cnt_nxt   = wr_cnt_r - 4'd1;
          wr_rst_nxt   = 1'b1;
        end
      end
      W_RUN: begin
        if (wr_frame_start) begin
          wr_pick_s    = 1'b1;
          wr_state_nxt = W_RST;
          wr_cnt_nxt   = RST_LOAD;
          wr_rst_nxt   = 1'b1;
          lat_idx_nxt  = wr_idx_r;
          lat_vld_nxt  = 1'b1;
          fresh_nxt    = 1'b1;
          drop_nxt     = fresh_r;
        end else begin
          wr_rst_nxt   = 1'b0;
        end
      end
      default: begin
        wr_state_nxt = W_IDLE;
        wr_rst_nxt   = 1'b0;
      end
    endcase

    case (rd_state_r)
      R_IDLE, R_RUN: begin
        rd_take_s = rd_frame_start && lat_vld_nxt;
        if (rd_take_s) begin
          if (fresh_nxt) begin
            rd_idx_nxt = lat_idx_nxt;
          end else begin
            repeat_nxt = 1'b1;
          end
          fresh_nxt      = 1'b0;
          rd_state_nxt   = R_RST;
          rd_cnt_nxt     = RST_LOAD;
          rd_rst_nxt     = 1'b1;
          read_valid_nxt = 1'b0;
        end else begin
          rd_rst_nxt     = 1'b0;
          read_valid_nxt = (rd_state_r == R_RUN);
        end
      end
      R_RST: begin
        if (rd_cnt_r == 4'd0) begin
          rd_state_nxt   = R_RUN;
          rd_rst_nxt     = 1'b0;
          read_valid_nxt = 1'b1;
        end else begin
          rd_cnt_nxt     = rd_cnt_r - 4'd1;
          rd_rst_nxt     = 1'b1;
          read_valid_nxt = 1'b0;
        end
      end
      default: begin
        rd_state_nxt   = R_IDLE;
        rd_rst_nxt     = 1'b0;
        read_valid_nxt = 1'b0;
      end
    endcase

    if (wr_pick_s) begin
      wr_idx_nxt = free_idx(rd_idx_nxt, lat_idx_nxt);
    end else begin
      wr_idx_nxt = wr_idx_r;
    end
  end

  // State, index and output registers; addresses follow the new indices on the same edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_state_r      <= W_IDLE;
      rd_state_r      <= R_IDLE;
      wr_cnt_r        <= 4'd0;
      rd_cnt_r        <= 4'd0;
      wr_idx_r        <= 2'd0;
      rd_idx_r        <= 2'd1;
      lat_idx_r       <= 2'd2;
      lat_vld_r       <= 1'b0;
      fresh_r         <= 1'b0;
      wr_rst          <= 1'b0;
      rd_rst          <= 1'b0;
      read_valid      <= 1'b0;
      frame_drop      <= 1'b0;
      frame_repeat    <= 1'b0;
      sdram_wr_b_addr <= buf_base(2'd0);
      sdram_wr_e_addr <= buf_base(2'd0) + FRAME_SIZE;
      sdram_rd_b_addr <= buf_base(2'd1);
      sdram_rd_e_addr <= buf_base(2'd1) + FRAME_SIZE;
    end else begin
      wr_state_r      <= wr_state_nxt;
      rd_state_r      <= rd_state_nxt;
      wr_cnt_r        <= wr_cnt_nxt;
      rd_cnt_r        <= rd_cnt_nxt;
      wr_idx_r        <= wr_idx_nxt;
      rd_idx_r        <= rd_idx_nxt;
      lat_idx_r       <= lat_idx_nxt;
      lat_vld_r       <= lat_vld_nxt;
      fresh_r         <= fresh_nxt;
      wr_rst          <= wr_rst_nxt;
      rd_rst          <= rd_rst_nxt;
      read_valid      <= read_valid_nxt;
      frame_drop      <= drop_nxt;
      frame_repeat    <= repeat_nxt;
      sdram_wr_b_addr <= buf_base(wr_idx_nxt);
      sdram_wr_e_addr <= buf_base(wr_idx_nxt) + FRAME_SIZE;
      sdram_rd_b_addr <= buf_base(rd_idx_nxt);
      sdram_rd_e_addr <= buf_base(rd_idx_nxt) + FRAME_SIZE;
    end
  end

  sdram_frame_sched_chk u_chk (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .wr_idx  (wr_idx_r),
    .rd_idx  (rd_idx_r),
    .lat_idx (lat_idx_r)
  );

endmodule

// Invariant checker: the writer never shares a buffer with the reader or the latest frame.
module sdram_frame_sched_chk (
  input logic       sys_clk,
  input logic       sys_rst,
  input logic [1:0] wr_idx,
  input logic [1:0] rd_idx,
  input logic [1:0] lat_idx
);

  // Buffer exclusivity and index range checked every cycle outside reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      assert (wr_idx != rd_idx && wr_idx != lat_idx)
        else $error("buffer overlap wr=%0d rd=%0d lat=%0d", wr_idx, rd_idx, lat_idx);
      assert (wr_idx != 2'd3 && rd_idx != 2'd3 && lat_idx != 2'd3)
        else $error("buffer index out of range");
    end else begin
    end
  end

endmodule

// File: tb/tb_sdram_frame_sched.sv
// Scoreboard bench for sdram_frame_sched: each scenario queues per-cycle stimulus with the
// expected output snapshot, then replays the queue and compares after every clock edge.
module tb_sdram_frame_sched;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        init_end = 1'b0;
  logic        wr_frame_start = 1'b0;
  logic        rd_frame_start = 1'b0;
  logic [23:0] sdram_wr_b_addr, sdram_wr_e_addr, sdram_rd_b_addr, sdram_rd_e_addr;
  logic [9:0]  wr_burst_len, rd_burst_len;
  logic        wr_rst, rd_rst, read_valid, frame_drop, frame_repeat;
  logic [1:0]  wr_buf_idx, rd_buf_idx;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [23:0] wb, we, rb, re;
    logic        wrst, rrst, rv;
    logic [1:0]  wi, ri;
    logic        drop, rep;
  } snap_t;

  typedef struct {
    logic  rst, ws, rs;
    snap_t exp;
    string tag;
  } step_t;

  step_t sb[$];

  sdram_frame_sched #(
    .BASE_ADDR  (24'h000100),
    .BUF_STRIDE (24'h000020),
    .FRAME_SIZE (24'h000010),
    .BURST_LEN  (10'd512),
    .RST_CYCLES (2)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .init_end        (init_end),
    .wr_frame_start  (wr_frame_start),
    .rd_frame_start  (rd_frame_start),
    .sdram_wr_b_addr (sdram_wr_b_addr),
    .sdram_wr_e_addr (sdram_wr_e_addr),
    .sdram_rd_b_addr (sdram_rd_b_addr),
    .sdram_rd_e_addr (sdram_rd_e_addr),
    .wr_burst_len    (wr_burst_len),
    .rd_burst_len    (rd_burst_len),
    .wr_rst          (wr_rst),
    .rd_rst          (rd_rst),
    .read_valid      (read_valid),
    .wr_buf_idx      (wr_buf_idx),
    .rd_buf_idx      (rd_buf_idx),
    .frame_drop      (frame_drop),
    .frame_repeat    (frame_repeat)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic snap_t mk(input logic [1:0] wi, input logic [1:0] ri, input logic wrst,
                               input logic rrst, input logic rv, input logic drop, input logic rep);
    snap_t s;
    s.wb   = 24'h000100 + 24'h000020 * {22'd0, wi};
    s.we   = s.wb + 24'h000010;
    s.rb   = 24'h000100 + 24'h000020 * {22'd0, ri};
    s.re   = s.rb + 24'h000010;
    s.wrst = wrst;
    s.rrst = rrst;
    s.rv   = rv;
    s.wi   = wi;
    s.ri   = ri;
    s.drop = drop;
    s.rep  = rep;
    return s;
  endfunction

  function automatic snap_t observe();
    return {sdram_wr_b_addr, sdram_wr_e_addr, sdram_rd_b_addr, sdram_rd_e_addr,
            wr_rst, rd_rst, read_valid, wr_buf_idx, rd_buf_idx, frame_drop, frame_repeat};
  endfunction

  function automatic step_t st(input logic rst, input logic ws, input logic rs,
                               input snap_t exp, input string tag);
    step_t s;
    s.rst = rst;
    s.ws  = ws;
    s.rs  = rs;
    s.exp = exp;
    s.tag = tag;
    return s;
  endfunction

  task automatic test_reset();
    snap_t obs;
    step_t s;
    sb.push_back(st(1'b1, 1'b0, 1'b0, mk(2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "reset_idle"));
    sb.push_back(st(1'b1, 1'b1, 1'b1, mk(2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "reset_starts"));
    while (sb.size() > 0) begin
      s = sb.pop_front();
      sys_rst = s.rst; wr_frame_start = s.ws; rd_frame_start = s.rs;
      @(posedge sys_clk); #1;
      wr_frame_start = 1'b0; rd_frame_start = 1'b0;
      obs = observe();
      n_cmp++;
      if (obs !== s.exp) begin
        n_bad++;
        $display("FAIL %s: observed %h expected %h", s.tag, obs, s.exp);
      end
    end
    sys_rst = 1'b0;
    n_cmp++;
    if ({wr_burst_len, rd_burst_len} !== {10'd512, 10'd512}) begin
      n_bad++;
      $display("FAIL burst_len: observed %0d/%0d expected 512/512", wr_burst_len, rd_burst_len);
    end
  endtask

  task automatic test_init_gating();
    snap_t obs;
    step_t s;
    init_end = 1'b0;
    sb.push_back(st(1'b0, 1'b1, 1'b0, mk(2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "gate_wr"));
    sb.push_back(st(1'b0, 1'b0, 1'b0, mk(2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "gate_quiet"));
    sb.push_back(st(1'b0, 1'b0, 1'b1, mk(2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "gate_rd"));
    while (sb.size() > 0) begin
      s = sb.pop_front();
      sys_rst = s.rst; wr_frame_start = s.ws; rd_frame_start = s.rs;
      @(posedge sys_clk); #1;
      wr_frame_start = 1'b0; rd_frame_start = 1'b0;
      obs = observe();
      n_cmp++;
      if (obs !== s.exp) begin
        n_bad++;
        $display("FAIL %s: observed %h expected %h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic test_first_frame();
    snap_t obs;
    step_t s;
    init_end = 1'b1;
    sb.push_back(st(1'b0, 1'b1, 1'b0, mk(2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "open_wr"));
    sb.push_back(st(1'b0, 1'b1, 1'b1, mk(2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "starts_in_rst"));
    sb.push_back(st(1'b0, 1'b0, 1'b0, mk(2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "wr_run"));
    sb.push_back(st(1'b0, 1'b1, 1'b0, mk(2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "commit_1"));
    sb.push_back(st(1'b0, 1'b0, 1'b0, mk(2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "commit_rst2"));
    sb.push_back(st(1'b0, 1'b0, 1'b0, mk(2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "commit_done"));
    sb.push_back(st(1'b0, 1'b0, 1'b1, mk(2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "rd_take"));
    sb.push_back(st(1'b0, 1'b0, 1'b0, mk(2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "rd_rst2"));
    sb.push_back(st(1'b0, 1'b0, 1'b0, mk(2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "rd_valid"));
    while (sb.size() > 0) begin
      s = sb.pop_front();
      sys_rst = s.rst; wr_frame_start = s.ws; rd_frame_start = s.rs;
      @(posedge sys_clk); #1;
      wr_frame_start = 1'b0; rd_frame_start = 1'b0;
      obs = observe();
      n_cmp++;
      if (obs !== s.exp) begin
        n_bad++;
        $display("FAIL %s: observed %h expected %h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic test_repeat();
    snap_t obs;
    step_t s;
    sb.push_back(st(1'b0, 1'b0, 1'b1, mk(2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), "repeat_pulse"));
    sb.push_back(st(1'b0, 1'b0, 1'b0, mk(2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "repeat_rst2"));
    sb.push_back(st(1'b0, 1'b0, 1'b0, mk(2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "repeat_valid"));
    while (sb.size() > 0) begin
      s = sb.pop_front();
      sys_rst = s.rst; wr_frame_start = s.ws; rd_frame_start = s.rs;
      @(posedge sys_clk); #1;
      wr_frame_start = 1'b0; rd_frame_start = 1'b0;
      obs = observe();
      n_cmp++;
      if (obs !== s.exp) begin
        n_bad++;
        $display("FAIL %s: observed %h expected %h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic test_drop();
    snap_t obs;
    step_t s;
    sb.push_back(st(1'b0, 1'b1, 1'b0, mk(2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), "commit_a"));
    sb.push_back(st(1'b0, 1'b0, 1'b0, mk(2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), "commit_a_rst"));
    sb.push_back(st(1'b0, 1'b0, 1'b0, mk(2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "commit_a_done"));
    sb.push_back(st(1'b0, 1'b1, 1'b0, mk(2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0), "drop_pulse"));
    sb.push_back(st(1'b0, 1'b0, 1'b0, mk(2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), "drop_clear"));
    sb.push_back(st(1'b0, 1'b0, 1'b0, mk(2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "drop_done"));
    while (sb.size() > 0) begin
      s = sb.pop_front();
      sys_rst = s.rst; wr_frame_start = s.ws; rd_frame_start = s.rs;
      @(posedge sys_clk); #1;
      wr_frame_start = 1'b0; rd_frame_start = 1'b0;
      obs = observe();
      n_cmp++;
      if (obs !== s.exp) begin
        n_bad++;
        $display("FAIL %s: observed %h expected %h", s.tag, obs, s.exp);
      end
    end
  endtask

  // Entered with wr=2, rd=0, lat=1 and an unread frame pending.
  task automatic test_simultaneous();
    snap_t obs;
    step_t s;
    sb.push_back(st(1'b0, 1'b1, 1'b1, mk(2'd0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0), "simul_both"));
    while (sb.size() > 0) begin
      s = sb.pop_front();
      sys_rst = s.rst; wr_frame_start = s.ws; rd_frame_start = s.rs;
      @(posedge sys_clk); #1;
      wr_frame_start = 1'b0; rd_frame_start = 1'b0;
      obs = observe();
      n_cmp++;
      if (obs !== s.exp) begin
        n_bad++;
        $display("FAIL %s: observed %h expected %h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    snap_t obs;
    step_t s;
    sb.push_back(st(1'b1, 1'b0, 1'b0, mk(2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "rst_mid_pulse"));
    sb.push_back(st(1'b0, 1'b1, 1'b0, mk(2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "rst_reopen"));
    sb.push_back(st(1'b0, 1'b0, 1'b1, mk(2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "rst_no_frame"));
    sb.push_back(st(1'b0, 1'b0, 1'b1, mk(2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "rst_rd_ignored"));
    while (sb.size() > 0) begin
      s = sb.pop_front();
      sys_rst = s.rst; wr_frame_start = s.ws; rd_frame_start = s.rs;
      @(posedge sys_clk); #1;
      wr_frame_start = 1'b0; rd_frame_start = 1'b0;
      obs = observe();
      n_cmp++;
      if (obs !== s.exp) begin
        n_bad++;
        $display("FAIL %s: observed %h expected %h", s.tag, obs, s.exp);
      end
    end
    sys_rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init_gating();
    test_first_frame();
    test_repeat();
    test_drop();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
